// File: rtl/mem_bus_master.sv
// ============================================================================
// Module      : mem_bus_master
// Description : Single-word RD/WR bus initiator with four-phase ACK handshake
//               and per-phase timeout abort towards MAIN_MEMORY.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_master #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_WIDTH  = 4
) (
  input  logic                     MEM_BUS_MASTER_CLOCK_50,
  input  logic                     MEM_BUS_MASTER_RESET_InLow,
  input  logic                     MEM_BUS_MASTER_REQ_In,
  input  logic                     MEM_BUS_MASTER_WE_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_WDATA_InBUS,
  output logic                     MEM_BUS_MASTER_BUSY_Out,
  output logic                     MEM_BUS_MASTER_DONE_Out,
  output logic                     MEM_BUS_MASTER_ERR_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_RDATA_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_data_OutBUS,
  output logic                     MEM_BUS_MASTER_RD_Out,
  output logic                     MEM_BUS_MASTER_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_data_InBUS,
  input  logic                     MEM_BUS_MASTER_ACK_In
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // The abort edge is the one on which the count would reach TIMEOUT_CYCLES,
  // so the strobe is high for exactly TIMEOUT_CYCLES cycles before ERR.
  localparam logic [TIMEOUT_WIDTH-1:0] c_timeout_last = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] c_count_max    = '1;

  state_t                   r_state, w_state_next;
  logic [TIMEOUT_WIDTH-1:0] r_count, w_count_next;
  logic                     r_busy, w_busy_next;
  logic                     r_done, w_done_next;
  logic                     r_err, w_err_next;
  logic                     r_rd, w_rd_next;
  logic                     r_wr, w_wr_next;
  logic [DATAWIDTH_BUS-1:0] r_rdata, w_rdata_next;
  logic [DATAWIDTH_BUS-1:0] r_addr, w_addr_next;
  logic [DATAWIDTH_BUS-1:0] r_wdata, w_wdata_next;
  logic                     w_expire;
  logic [TIMEOUT_WIDTH-1:0] w_count_inc;

  assign w_expire    = (r_count == c_timeout_last);
  assign w_count_inc = (r_count == c_count_max) ? r_count : r_count + TIMEOUT_WIDTH'(1);

  always_ff @(posedge MEM_BUS_MASTER_CLOCK_50 or negedge MEM_BUS_MASTER_RESET_InLow) begin
    if (!MEM_BUS_MASTER_RESET_InLow) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      r_rd    <= w_rd_next;
      r_wr    <= w_wr_next;
      r_rdata <= w_rdata_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_rd_next    = r_rd;
    w_wr_next    = r_wr;
    w_rdata_next = r_rdata;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;

    case (r_state)
      ST_IDLE: begin
        if (MEM_BUS_MASTER_REQ_In) begin
          w_state_next = ST_ACCESS;
          w_count_next = '0;
          w_busy_next  = 1'b1;
          w_rd_next    = ~MEM_BUS_MASTER_WE_In;
          w_wr_next    = MEM_BUS_MASTER_WE_In;
          w_addr_next  = MEM_BUS_MASTER_ADDRESS_InBUS;
          w_wdata_next = MEM_BUS_MASTER_WDATA_InBUS;
        end
      end
      ST_ACCESS: begin
        // ACK takes priority over an expiring count on the same edge.
        if (MEM_BUS_MASTER_ACK_In) begin
          w_state_next = ST_RELEASE;
          w_count_next = '0;
          w_done_next  = 1'b1;
          w_rd_next    = 1'b0;
          w_wr_next    = 1'b0;
          if (r_rd) begin
            w_rdata_next = MEM_BUS_MASTER_data_InBUS;
          end
        end else if (w_expire) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
          w_busy_next  = 1'b0;
          w_err_next   = 1'b1;
          w_rd_next    = 1'b0;
          w_wr_next    = 1'b0;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      ST_RELEASE: begin
        if (!MEM_BUS_MASTER_ACK_In) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
          w_busy_next  = 1'b0;
        end else if (w_expire) begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
          w_busy_next  = 1'b0;
          w_err_next   = 1'b1;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
        w_busy_next  = 1'b0;
        w_rd_next    = 1'b0;
        w_wr_next    = 1'b0;
      end
    endcase
  end

  assign MEM_BUS_MASTER_BUSY_Out       = r_busy;
  assign MEM_BUS_MASTER_DONE_Out       = r_done;
  assign MEM_BUS_MASTER_ERR_Out        = r_err;
  assign MEM_BUS_MASTER_RD_Out         = r_rd;
  assign MEM_BUS_MASTER_WR_Out         = r_wr;
  assign MEM_BUS_MASTER_RDATA_OutBUS   = r_rdata;
  assign MEM_BUS_MASTER_ADDRESS_OutBUS = r_addr;
  assign MEM_BUS_MASTER_data_OutBUS    = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_master.sv
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Self-checking bench for mem_bus_master with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_master;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we_in, ack;
  logic [31:0] addr_in, wdata_in, mem_data;
  logic        busy, done, err, rd, wr;
  logic [31:0] rdata, addr_out, data_out;

  logic [31:0] mem [0:15];
  logic [31:0] exp_rdata;
  int          n_vec = 0;
  int          n_err = 0;

  mem_bus_master #(.DATAWIDTH_BUS(32), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(4)) dut (
    .MEM_BUS_MASTER_CLOCK_50       (clk),
    .MEM_BUS_MASTER_RESET_InLow    (rst_n),
    .MEM_BUS_MASTER_REQ_In         (req),
    .MEM_BUS_MASTER_WE_In          (we_in),
    .MEM_BUS_MASTER_ADDRESS_InBUS  (addr_in),
    .MEM_BUS_MASTER_WDATA_InBUS    (wdata_in),
    .MEM_BUS_MASTER_BUSY_Out       (busy),
    .MEM_BUS_MASTER_DONE_Out       (done),
    .MEM_BUS_MASTER_ERR_Out        (err),
    .MEM_BUS_MASTER_RDATA_OutBUS   (rdata),
    .MEM_BUS_MASTER_ADDRESS_OutBUS (addr_out),
    .MEM_BUS_MASTER_data_OutBUS    (data_out),
    .MEM_BUS_MASTER_RD_Out         (rd),
    .MEM_BUS_MASTER_WR_Out         (wr),
    .MEM_BUS_MASTER_data_InBUS     (mem_data),
    .MEM_BUS_MASTER_ACK_In         (ack)
  );

  always #5 clk = ~clk;

  // One transfer. The memory raises ACK so that it is sampled d edges after
  // the request edge and keeps it high for h edges. Expected behaviour is a
  // timeline computed from the handshake rules: DONE at d if d<=T, else ERR
  // at T; after DONE, IDLE at d+h unless ACK stays high T more edges (ERR).
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int d, input int h, input bit hold, input bit noise);
    int strobe_end, done_e, err_e, end_e;
    logic [4:0] exp_ctl;
    if (d <= T) begin
      strobe_end = d;
      done_e     = d;
      if (h >= T + 1) begin
        err_e = d + T;
        end_e = d + T;
      end else begin
        err_e = -1;
        end_e = d + h;
      end
    end else begin
      strobe_end = T;
      done_e     = -1;
      err_e      = T;
      end_e      = T;
    end
    req = 1'b1; we_in = we; addr_in = addr; wdata_in = wdata; ack = 1'b0;
    mem_data = $urandom;
    @(posedge clk); #1;
    for (int c = 0; c <= end_e; c++) begin
      if (c == done_e && !we) exp_rdata = mem[addr[3:0]];
      exp_ctl = {c < end_e, !we && (c < strobe_end), we && (c < strobe_end), c == done_e, c == err_e};
      n_vec++;
      if ({busy, rd, wr, done, err} !== exp_ctl) begin
        n_err++;
        $display("FAIL ctl{busy,rd,wr,done,err} c=%0d: got %b expected %b", c, {busy, rd, wr, done, err}, exp_ctl);
      end
      n_vec++;
      if (rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL rdata c=%0d: got %h expected %h", c, rdata, exp_rdata);
      end
      n_vec++;
      if (addr_out !== addr) begin
        n_err++;
        $display("FAIL addr_out c=%0d: got %h expected %h", c, addr_out, addr);
      end
      n_vec++;
      if (data_out !== wdata) begin
        n_err++;
        $display("FAIL data_out c=%0d: got %h expected %h", c, data_out, wdata);
      end
      if (c == end_e) break;
      ack      = (c + 1 >= d) && (c + 1 < d + h);
      mem_data = (c + 1 == d) ? mem[addr[3:0]] : $urandom;
      if (noise) begin
        req = $urandom_range(0, 1); we_in = $urandom_range(0, 1);
        addr_in = $urandom; wdata_in = $urandom;
      end else if (!hold) begin
        req = 1'b0;
      end
      @(posedge clk); #1;
    end
    ack = 1'b0;
    if (!hold) req = 1'b0;
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({busy, rd, wr, done, err} !== 5'b0) begin
        n_err++;
        $display("FAIL idle_ctl i=%0d: got %b expected 00000", i, {busy, rd, wr, done, err});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we_in = 1'b0; ack = 1'b0;
    addr_in = '0; wdata_in = '0; mem_data = '0; exp_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, rd, wr, done, err, rdata, addr_out, data_out} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0", {busy, rd, wr, done, err, rdata, addr_out, data_out});
    end
    rst_n = 1'b1;
    ack = 1'b1;
    mem_data = 32'h1234_5678;
    check_idle(2);
    ack = 1'b0;
    n_vec++;
    if (rdata !== 32'h0) begin
      n_err++;
      $display("FAIL idle_ack_rdata: got %h expected 00000000", rdata);
    end
  endtask

  task automatic test_read();
    run_txn(1'b0, 32'd3, 32'h0, 2, 2, 1'b0, 1'b0);
    check_idle(1);
    run_txn(1'b0, 32'd5, 32'hFFFF_0000, 1, 1, 1'b0, 1'b0);
    check_idle(1);
  endtask

  task automatic test_write();
    run_txn(1'b1, 32'd8, 32'hDEAD_BEEF, 3, 2, 1'b0, 1'b0);
    check_idle(1);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'd4, 32'h0, 100, 1, 1'b0, 1'b0);
    check_idle(1);
    run_txn(1'b1, 32'd6, 32'hA5A5_5A5A, 16, 3, 1'b0, 1'b0);
    check_idle(1);
  endtask

  task automatic test_boundary();
    run_txn(1'b0, 32'd7, 32'h0, T, 1, 1'b0, 1'b0);
    check_idle(1);
    run_txn(1'b0, 32'd9, 32'h0, 2, T + 1, 1'b0, 1'b0);
    check_idle(1);
    run_txn(1'b1, 32'd10, 32'h0BAD_F00D, 2, T, 1'b0, 1'b0);
    check_idle(1);
  endtask

  task automatic test_busy_req();
    run_txn(1'b0, 32'd11, 32'h0, 6, 4, 1'b0, 1'b1);
    check_idle(3);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 32'd0, 32'h0, 2, 2, 1'b1, 1'b0);
    run_txn(1'b0, 32'd1, 32'h0, 3, 1, 1'b0, 1'b0);
    check_idle(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
              int'($urandom_range(1, 17)), int'($urandom_range(1, 17)), 1'b0, 1'($urandom_range(0, 1)));
    end
    check_idle(1);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; we_in = 1'b0; addr_in = 32'd12; wdata_in = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_rdata = '0;
    n_vec++;
    if ({busy, rd, wr, done, err, rdata, addr_out} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: got %h expected 0", {busy, rd, wr, done, err, rdata, addr_out});
    end
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, rd, wr, done, err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_mid_held: got %b expected 00000", {busy, rd, wr, done, err});
    end
    rst_n = 1'b1;
    check_idle(2);
    run_txn(1'b0, 32'd13, 32'h0, 4, 2, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_boundary();
    test_busy_req();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
